sdram_burst_reader: RTL
=======================

Name: sdram_burst_reader

Overview:
Parametrised next-generation SDRAM read controller. It sits behind sdram_init and drives the SDRAM command, bank and address bus once init_end is high.
- Issues ACTIVE → READ (full-page) → PRECHARGE sequences with programmable tRCD, tRP and CAS latency.
- Returns bursts of 1..2^LEN_W words.
- Automatically splits any burst that crosses a page boundary into two row segments.

Parameters:
- BA_W, 2, bank address width
- ROW_W, 12, row width; also the width of the SDRAM address bus
- COL_W, 9, column width; must be ≤10 so A10 stays free
- DATA_W, 16, data width
- LEN_W, 8, burst length field width
- CAS_LAT, 3, CAS latency in cycles; legal values 2 or 3
- T_RCD, 2, ACTIVE-to-READ delay in cycles; ≥1
- T_RP, 2, PRECHARGE-to-next-command delay in cycles; ≥1

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- init_end  in  1  SDRAM initialisation complete
- rd_en  in  1  read request; sampled only in IDLE
- rd_addri  in  BA_W+ROW_W+COL_W  start address {bank,row,col}
- rd_blength  in  LEN_W  word count; 0 means 2^LEN_W
- rd_din  in  DATA_W  data from the SDRAM DQ bus
- rd_ack  out  1  one-cycle pulse when the request is accepted
- rd_busy  out  1  high from acceptance through rd_end
- rd_valid  out  1  rd_datao holds a valid word
- rd_datao  out  DATA_W  read data
- rd_end  out  1  one-cycle pulse when the transaction is complete
- rd_cmdo  out  4  {cs_n,ras_n,cas_n,we_n}
- rd_bao  out  BA_W  bank address
- rd_addro  out  ROW_W  row/column/A10 address

Behaviour:
- Commands: NOP=0111, ACT=0011, READ=0101, PRE=0010.
- Reset values: rd_cmdo=NOP; rd_bao=0; rd_addro=0; all strobes 0; rd_datao=0; FSM=IDLE.
- Reset is honoured in any state, including mid-burst. The next cycle drives NOP and in-flight data is discarded with no rd_valid.
- All outputs are registered.
- IDLE:
  - If init_end & rd_en: latch address and length (0 → 2^LEN_W), pulse rd_ack, raise rd_busy, go to ACT.
  - rd_en is ignored while init_end=0.
- ACT: drive ACT with rd_bao=bank and rd_addro=row. Go to WAIT_RCD.
- WAIT_RCD: NOP for T_RCD-1 cycles. Go to RD.
- RD:
  - Drive READ with rd_addro = col zero-extended and A10=0.
  - Segment length seg = min(remaining, 2^COL_W - col).
  - Then NOP for seg-1 cycles (BURST).
- PRE: drive PRE (A10=1, all banks) exactly seg cycles after READ. This terminates the full-page burst. Go to WAIT_RP.
- WAIT_RP: NOP for T_RP-1 cycles.
  - If words remain: {bank,row} += 1 (wraps to 0 from all-ones), col=0, go to ACT.
  - Otherwise go to DONE.
- Data path, with READ issued at cycle t:
  - rd_din is sampled at t+CAS_LAT … t+CAS_LAT+seg-1.
  - Each sample is registered: rd_valid/rd_datao appear one cycle later.
  - rd_valid is contiguous within a segment.
  - A cycle-accurate capture shift register, CAS_LAT+1 deep, tags the sample cycles. It runs independently of the FSM, so PRE/ACT of the next segment overlap the data tail.
- DONE: wait until the final rd_valid has been presented. Next cycle: pulse rd_end, drop rd_busy, go to IDLE.
- Back-to-back: rd_en held high starts a new request the cycle after rd_end (IDLE re-samples).
- rd_en deasserting mid-transaction has no effect; there is no abort.
- Total rd_valid count per transaction equals the requested length exactly.
- Page-crossing segments deliver addresses in order col..2^COL_W-1, then 0.. of the next row.

Test Plan:
1. Defaults; init_end=1, rd_en pulse, addr={2'd0,12'd1,9'd1}, blength=8 → ACT row 1; READ col 1 two cycles later; PRE 8 cycles after READ; 8 contiguous rd_valid starting 4 cycles after READ; data matches model words col 1..8; single rd_end.
2. addr col=508, blength=8 → segment 1 is 4 words (cols 508..511), PRE, ACT row+1, READ col 0, 4 more words; 8 rd_valid total; one rd_end.
3. blength=0, col=0 → 256 rd_valid, no page split (256 < 512), one ACT/READ/PRE.
4. CAS_LAT=2, T_RCD=3 build → READ 3 cycles after ACT; first rd_valid 3 cycles after READ.
5. sys_rst asserted on the 3rd rd_valid → next cycle rd_cmdo=NOP, rd_valid=0, rd_busy=0; no further rd_valid; a new request then completes normally.
6. rd_en high while init_end=0 → no ACT, no rd_ack. init_end rises → rd_ack in the next cycle. rd_en held high → a second transaction starts immediately after rd_end.

Source files
------------

// File: rtl/sdram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : sdram_burst_reader
// Description : SDRAM read controller. Issues ACTIVE -> full-page READ ->
//               PRECHARGE per row segment, splitting page-crossing bursts.
//               Returns 1..2^LEN_W words with programmable tRCD/tRP/CL.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_burst_reader #(
  parameter int BA_W    = 2,
  parameter int ROW_W   = 12,
  parameter int COL_W   = 9,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 8,
  parameter int CAS_LAT = 3,
  parameter int T_RCD   = 2,
  parameter int T_RP    = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        init_end,
  input  logic                        rd_en,
  input  logic [BA_W+ROW_W+COL_W-1:0] rd_addri,
  input  logic [LEN_W-1:0]            rd_blength,
  input  logic [DATA_W-1:0]           rd_din,
  output logic                        rd_ack,
  output logic                        rd_busy,
  output logic                        rd_valid,
  output logic [DATA_W-1:0]           rd_datao,
  output logic                        rd_end,
  output logic [3:0]                  rd_cmdo,
  output logic [BA_W-1:0]             rd_bao,
  output logic [ROW_W-1:0]            rd_addro
);

  // Counters must hold both a full burst length and a full page length.
  localparam int CNT_W = ((LEN_W > COL_W) ? LEN_W : COL_W) + 1;

  localparam logic [3:0]       c_cmd_nop  = 4'b0111;
  localparam logic [3:0]       c_cmd_act  = 4'b0011;
  localparam logic [3:0]       c_cmd_read = 4'b0101;
  localparam logic [3:0]       c_cmd_pre  = 4'b0010;
  localparam logic [ROW_W-1:0] c_a10      = ROW_W'(1) << 10;
  localparam logic [CNT_W-1:0] c_page     = CNT_W'(1) << COL_W;
  localparam logic [CNT_W-1:0] c_full_len = CNT_W'(1) << LEN_W;
  localparam logic [CNT_W-1:0] c_rcd_load = CNT_W'((T_RCD >= 2) ? T_RCD - 2 : 0);
  localparam logic [CNT_W-1:0] c_rp_load  = CNT_W'((T_RP >= 2) ? T_RP - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_WAIT_RCD, S_RD, S_BURST, S_PRE, S_WAIT_RP, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [BA_W-1:0]    r_bank, w_bank_nxt;
  logic [ROW_W-1:0]   r_row, w_row_nxt;
  logic [COL_W-1:0]   r_col, w_col_nxt;
  logic [CNT_W-1:0]   r_rem, w_rem_nxt;      // words not yet covered by a READ
  logic [CNT_W-1:0]   r_tmr, w_tmr_nxt;      // wait-state down counter
  logic [CNT_W-1:0]   r_out_left;            // words not yet presented on rd_datao
  logic [CAS_LAT:0]   r_cap;                 // tags cycles whose DQ sample is data
  logic [3:0]         w_cmd;
  logic [BA_W-1:0]    w_ba;
  logic [ROW_W-1:0]   w_addr;
  logic               w_ack, w_end, w_rp_done, w_slot;
  logic [CNT_W-1:0]   w_len_in, w_page_left, w_seg;

  assign w_len_in    = (rd_blength == '0) ? c_full_len : CNT_W'(rd_blength);
  assign w_page_left = c_page - CNT_W'(r_col);
  assign w_seg       = (r_rem < w_page_left) ? r_rem : w_page_left;
  // A word slot is every cycle from READ through the last burst NOP.
  assign w_slot      = (r_state == S_RD) || (r_state == S_BURST);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state, command and address-pointer logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd       = c_cmd_nop;
    w_ba        = rd_bao;
    w_addr      = rd_addro;
    w_ack       = 1'b0;
    w_end       = 1'b0;
    w_rp_done   = 1'b0;
    w_bank_nxt  = r_bank;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_rem_nxt   = r_rem;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      S_IDLE: begin
        if (init_end && rd_en) begin
          w_ack = 1'b1;
          {w_bank_nxt, w_row_nxt, w_col_nxt} = rd_addri;
          w_rem_nxt   = w_len_in;
          w_state_nxt = S_ACT;
        end
      end
      S_ACT: begin
        w_cmd       = c_cmd_act;
        w_ba        = r_bank;
        w_addr      = r_row;
        w_tmr_nxt   = c_rcd_load;
        w_state_nxt = (T_RCD == 1) ? S_RD : S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (r_tmr == '0) w_state_nxt = S_RD;
        else             w_tmr_nxt   = r_tmr - 1'b1;
      end
      S_RD: begin
        w_cmd       = c_cmd_read;
        w_ba        = r_bank;
        w_addr      = ROW_W'(r_col);
        w_rem_nxt   = r_rem - w_seg;
        w_tmr_nxt   = w_seg - CNT_W'(2);
        w_state_nxt = (w_seg == CNT_W'(1)) ? S_PRE : S_BURST;
      end
      S_BURST: begin
        if (r_tmr == '0) w_state_nxt = S_PRE;
        else             w_tmr_nxt   = r_tmr - 1'b1;
      end
      S_PRE: begin
        // PRE ends the full-page burst and closes all banks (A10 high).
        w_cmd       = c_cmd_pre;
        w_ba        = r_bank;
        w_addr      = c_a10;
        w_tmr_nxt   = c_rp_load;
        w_state_nxt = S_WAIT_RP;
        w_rp_done   = (T_RP == 1);
      end
      S_WAIT_RP: begin
        if (r_tmr == '0) w_rp_done = 1'b1;
        else             w_tmr_nxt = r_tmr - 1'b1;
      end
      S_DONE: begin
        if (r_out_left == '0) begin
          w_end       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // After tRP either open the next row (linear address carry) or finish.
    if (w_rp_done) begin
      if (r_rem != '0) begin
        {w_bank_nxt, w_row_nxt} = {r_bank, r_row} + (BA_W+ROW_W)'(1);
        w_col_nxt   = '0;
        w_state_nxt = S_ACT;
      end else begin
        w_state_nxt = S_DONE;
      end
    end
  end

  // Registered outputs, address pointers and the CAS-latency capture pipe.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_cmdo    <= c_cmd_nop;
      rd_bao     <= '0;
      rd_addro   <= '0;
      rd_ack     <= 1'b0;
      rd_end     <= 1'b0;
      rd_busy    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_datao   <= '0;
      r_cap      <= '0;
      r_out_left <= '0;
      r_bank     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_rem      <= '0;
      r_tmr      <= '0;
    end else begin
      rd_cmdo  <= w_cmd;
      rd_bao   <= w_ba;
      rd_addro <= w_addr;
      rd_ack   <= w_ack;
      rd_end   <= w_end;
      if (w_ack)                  rd_busy <= 1'b1;
      else if (r_state == S_IDLE) rd_busy <= 1'b0;
      r_cap    <= {r_cap[CAS_LAT-1:0], w_slot};
      rd_valid <= r_cap[CAS_LAT];
      if (r_cap[CAS_LAT]) rd_datao <= rd_din;
      if (w_ack)               r_out_left <= w_len_in;
      else if (r_cap[CAS_LAT]) r_out_left <= r_out_left - 1'b1;
      r_bank <= w_bank_nxt;
      r_row  <= w_row_nxt;
      r_col  <= w_col_nxt;
      r_rem  <= w_rem_nxt;
      r_tmr  <= w_tmr_nxt;
    end
  end

endmodule
`default_nettype wire
